// File: rtl/alu_commit.sv
// alu_commit: writeback stage downstream of the ALU.
// This stage latches the ALU result, the flags and the destination descriptor
// when start is seen in IDLE. It then commits in one of two ways:
//   - Register path: one cycle with flags_we, reg_we and done.
//   - Memory path: one byte per acknowledged request, least-significant byte
//     first, followed by a one-cycle DONE.
// CMP (alumode 7) always takes the register path and writes only the flags.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   start                   capture request (ignored while busy)
//   isize, opsize           operand size (byte / 16-bit / 32-bit)
//   alumode                 ALU operation; 7 = CMP
//   result, flags_in        ALU outputs to be committed
//   dst_mem, dst_reg,       destination descriptor
//   dst_addr
//   busy, done              status and completion pulse
//   flags_we, flags_out     flags write strobe and captured flags
//   reg_we, reg_idx,        register-file write port
//   reg_size, reg_data
//   mem_req, mem_addr,      8-bit memory write bus
//   mem_data, mem_ack
//   mem_lock                bus lock (only with ALU_COMMIT_LOCK_EN)
//
// Configuration macro: ALU_COMMIT_LOCK_EN adds the mem_lock output. It is
// held through every byte of a memory write so that no other master can
// interleave between bytes.
module alu_commit #(
  parameter int ABITS = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             isize,
  input  logic             opsize,
  input  logic [2:0]       alumode,
  input  logic [31:0]      result,
  input  logic [11:0]      flags_in,
  input  logic             dst_mem,
  input  logic [2:0]       dst_reg,
  input  logic [ABITS-1:0] dst_addr,
  output logic             busy,
  output logic             done,
  output logic             flags_we,
  output logic [11:0]      flags_out,
  output logic             reg_we,
  output logic [2:0]       reg_idx,
  output logic [1:0]       reg_size,
  output logic [31:0]      reg_data,
  output logic             mem_req,
  output logic [ABITS-1:0] mem_addr,
  output logic [7:0]       mem_data,
  input  logic             mem_ack
`ifdef ALU_COMMIT_LOCK_EN
  ,
  output logic             mem_lock
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REG  = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [11:0]      flags_q;
  logic [2:0]       idx_q;
  logic [1:0]       size_q;
  logic [31:0]      data_q;
  logic [ABITS-1:0] base_q;
  logic [1:0]       k_q;
  logic [1:0]       last_q;
  logic             cmp_q;
  logic             first_q;

  // Decode of the incoming operand size
  logic [1:0]  size_in;
  logic [1:0]  last_in;
  logic [31:0] data_in;

  always_comb begin
    size_in = 2'd0;
    last_in = 2'd0;
    if (isize) begin
      size_in = opsize ? 2'd2 : 2'd1;
      last_in = opsize ? 2'd3 : 2'd1;
    end
    data_in = '0;
    case (size_in)
      2'd0:    data_in = {24'h0, result[7:0]};
      2'd1:    data_in = {16'h0, result[15:0]};
      default: data_in = result;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (!dst_mem || alumode == 3'd7) ? REG : MEM;
        end
      end
      REG:  state_d = IDLE;
      MEM: begin
        if (mem_ack && k_q == last_q) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and captured operation
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      flags_q <= 12'h002;
      idx_q   <= '0;
      size_q  <= '0;
      data_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
      last_q  <= '0;
      cmp_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            flags_q <= flags_in;
            idx_q   <= dst_reg;
            size_q  <= size_in;
            data_q  <= data_in;
            base_q  <= dst_addr;
            k_q     <= '0;
            last_q  <= last_in;
            cmp_q   <= (alumode == 3'd7);
            first_q <= 1'b1;
          end
        end
        MEM: begin
          // first_q marks the first MEM cycle, which may stretch while
          // byte 0 waits for its ack, so it cannot be derived from k_q.
          first_q <= 1'b0;
          if (mem_ack && k_q != last_q) begin
            k_q <= k_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == REG) || (state_q == DONE);
    flags_we = (state_q == REG) || ((state_q == MEM) && first_q);
    reg_we   = (state_q == REG) && !cmp_q;
    mem_req  = (state_q == MEM);
  end

`ifdef ALU_COMMIT_LOCK_EN
  assign mem_lock = (state_q == MEM);
`endif

  assign flags_out = flags_q;
  assign reg_idx   = idx_q;
  assign reg_size  = size_q;
  assign reg_data  = data_q;
  // The address wraps modulo 2^ABITS through the natural truncation of the sum.
  assign mem_addr  = base_q + ABITS'(k_q);
  assign mem_data  = data_q[{k_q, 3'b000} +: 8];

endmodule

// File: tb/tb_alu_commit.sv
// tb_alu_commit: directed, table-driven bench for alu_commit.
// Register and CMP commits come from a vector table. The memory-path corner
// cases (address wrap with slow acks, start while busy, reset mid-write) are
// hand-written sequences.
module tb_alu_commit;

  localparam int ABITS = 20;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             isize;
  logic             opsize;
  logic [2:0]       alumode;
  logic [31:0]      result;
  logic [11:0]      flags_in;
  logic             dst_mem;
  logic [2:0]       dst_reg;
  logic [ABITS-1:0] dst_addr;
  logic             busy;
  logic             done;
  logic             flags_we;
  logic [11:0]      flags_out;
  logic             reg_we;
  logic [2:0]       reg_idx;
  logic [1:0]       reg_size;
  logic [31:0]      reg_data;
  logic             mem_req;
  logic [ABITS-1:0] mem_addr;
  logic [7:0]       mem_data;
  logic             mem_ack;
`ifdef ALU_COMMIT_LOCK_EN
  logic             mem_lock;
`endif

  alu_commit #(.ABITS(ABITS)) dut (
    .clock(clock), .reset(reset), .start(start), .isize(isize),
    .opsize(opsize), .alumode(alumode), .result(result),
    .flags_in(flags_in), .dst_mem(dst_mem), .dst_reg(dst_reg),
    .dst_addr(dst_addr), .busy(busy), .done(done), .flags_we(flags_we),
    .flags_out(flags_out), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_size(reg_size), .reg_data(reg_data), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack)
`ifdef ALU_COMMIT_LOCK_EN
    , .mem_lock(mem_lock)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int fw_cnt = 0;
  int done_cnt = 0;

  // Strobe counters sampled mid-cycle
  always @(negedge clock) begin
    if (flags_we) fw_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic is, input logic os, input logic [2:0] m,
                        input logic [31:0] r, input logic [11:0] f,
                        input logic dm, input logic [2:0] dr,
                        input logic [ABITS-1:0] da);
    isize = is; opsize = os; alumode = m; result = r; flags_in = f;
    dst_mem = dm; dst_reg = dr; dst_addr = da;
  endtask

  typedef struct {
    logic        is;
    logic        os;
    logic [2:0]  mode;
    logic [31:0] res;
    logic [11:0] fl;
    logic        dmem;
    logic [2:0]  dreg;
    logic        exp_we;
    logic [1:0]  exp_size;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fw0;
    int dn0;
    vecs[0] = '{1'b1, 1'b0, 3'd0, 32'h0001_1234, 12'h0AB, 1'b0, 3'd3, 1'b1, 2'd1, 32'h0000_1234};
    vecs[1] = '{1'b0, 1'b0, 3'd2, 32'hFFFF_FF5A, 12'h801, 1'b0, 3'd5, 1'b1, 2'd0, 32'h0000_005A};
    vecs[2] = '{1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF, 12'hFFF, 1'b0, 3'd7, 1'b1, 2'd2, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b1, 3'd7, 32'h1234_5678, 12'h046, 1'b1, 3'd2, 1'b0, 2'd2, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 3'd7, 32'h0000_00AB, 12'h010, 1'b0, 3'd1, 1'b0, 2'd0, 32'h0000_00AB};

    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    set_op(1'b0, 1'b0, 3'd0, 32'h0, 12'h0, 1'b0, 3'd0, '0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags_we", flags_we, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_flags_out", flags_out, 32'h002);
    chk("rst_reg_data", reg_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_reg_idx", reg_idx, 0);
    chk("rst_reg_size", reg_size, 0);
`ifdef ALU_COMMIT_LOCK_EN
    chk("rst_mem_lock", mem_lock, 0);
`endif
    reset = 1'b0;
    tick();

    // Register and CMP paths, applied back-to-back (start again at T+2)
    for (int i = 0; i < 5; i++) begin
      set_op(vecs[i].is, vecs[i].os, vecs[i].mode, vecs[i].res, vecs[i].fl,
             vecs[i].dmem, vecs[i].dreg, 20'h00100);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("vec_flags_we", flags_we, 1);
      chk("vec_done", done, 1);
      chk("vec_busy", busy, 1);
      chk("vec_reg_we", reg_we, vecs[i].exp_we);
      chk("vec_reg_idx", reg_idx, vecs[i].dreg);
      chk("vec_reg_size", reg_size, vecs[i].exp_size);
      chk("vec_reg_data", reg_data, vecs[i].exp_data);
      chk("vec_flags_out", flags_out, vecs[i].fl);
      chk("vec_mem_req", mem_req, 0);
      tick();
      chk("vec_busy_t2", busy, 0);
      chk("vec_done_t2", done, 0);
      chk("vec_mem_req_t2", mem_req, 0);
    end

    // Dword to memory, address wrap, each byte acked on its third cycle
    fw0 = fw_cnt; dn0 = done_cnt;
    set_op(1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF, 12'h123, 1'b1, 3'd4, 20'hFFFFE);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wrap_first_flags_we", flags_we, 1);
    chk("wrap_flags_out", flags_out, 32'h123);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] word;
      logic [19:0] ea;
      word = 32'hDEAD_BEEF;
      ea = 20'hFFFFE + 20'(k);
      for (int w = 0; w < 3; w++) begin
        chk("wrap_mem_req", mem_req, 1);
        chk("wrap_mem_addr", mem_addr, ea);
        chk("wrap_mem_data", mem_data, word[8*k +: 8]);
        chk("wrap_done_low", done, 0);
`ifdef ALU_COMMIT_LOCK_EN
        chk("wrap_mem_lock", mem_lock, 1);
`endif
        mem_ack = (w == 2);
        tick();
        mem_ack = 1'b0;
      end
    end
    chk("wrap_done", done, 1);
    chk("wrap_done_mem_req", mem_req, 0);
`ifdef ALU_COMMIT_LOCK_EN
    chk("wrap_done_mem_lock", mem_lock, 0);
`endif
    tick();
    chk("wrap_idle_busy", busy, 0);
    chk("wrap_done_count", done_cnt - dn0, 1);
    chk("wrap_flags_we_count", fw_cnt - fw0, 1);

    // start held while busy in MEM, ack tied high
    fw0 = fw_cnt; dn0 = done_cnt;
    set_op(1'b1, 1'b0, 3'd1, 32'h0000_BEEF, 12'h555, 1'b1, 3'd0, 20'h00040);
    start = 1'b1; mem_ack = 1'b1;
    tick();
    chk("sb_mem_req0", mem_req, 1);
    chk("sb_addr0", mem_addr, 20'h00040);
    chk("sb_data0", mem_data, 8'hEF);
    tick();
    start = 1'b0;
    chk("sb_addr1", mem_addr, 20'h00041);
    chk("sb_data1", mem_data, 8'hBE);
    chk("sb_flags_we1", flags_we, 0);
    tick();
    chk("sb_done", done, 1);
    tick();
    chk("sb_busy_idle", busy, 0);
    tick();
    chk("sb_not_queued", busy, 0);
    mem_ack = 1'b0;
    chk("sb_done_count", done_cnt - dn0, 1);
    chk("sb_flags_we_count", fw_cnt - fw0, 1);

    // Reset after the first byte ack of a word write
    dn0 = done_cnt;
    set_op(1'b1, 1'b0, 3'd0, 32'h0000_A55A, 12'h3C0, 1'b1, 3'd0, 20'h00010);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_data0", mem_data, 8'h5A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rm_addr1", mem_addr, 20'h00011);
    chk("rm_data1", mem_data, 8'hA5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_mem_req", mem_req, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
`ifdef ALU_COMMIT_LOCK_EN
    chk("rm_mem_lock", mem_lock, 0);
`endif
    tick();
    chk("rm_still_idle", busy, 0);
    chk("rm_no_done", done_cnt - dn0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
